// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fb_pkg
//  Description : Shared framebuffer geometry, pixel/address types and the
//                slot classification used by the framebuffer slot arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package fb_pkg;

    localparam int WIDTH     = 640;
    localparam int HEIGHT    = 480;
    localparam int MEM_DEPTH = WIDTH * HEIGHT;
    localparam int ADDR_W    = $clog2(MEM_DEPTH);
    localparam int DATA_W    = 24;

    typedef logic [DATA_W-1:0] pixel_t;
    typedef logic [ADDR_W-1:0] fb_addr_t;

    // Owner of the current memory cycle
    typedef enum logic {
        SLOT_DISP = 1'b0,
        SLOT_REQ  = 1'b1
    } slot_t;

endpackage : fb_pkg
`default_nettype wire

// File: rtl/fb_slot_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-way round-robin arbiter. A lone requester is granted
//                directly; on contention the pointer picks the winner. After
//                each granted transfer the pointer moves to the other side.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       ptr
);

    logic r_ptr;

    // Grant selection: single requester wins outright, pointer breaks ties
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = r_ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // Pointer moves to the requester that did not win the last transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 1'b0;
        end else if (advance && (|grant)) begin
            r_ptr <= grant[0];
        end
    end

    assign ptr = r_ptr;

endmodule : rr_arb2
`default_nettype wire

// File: rtl/fb_slot_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fb_slot_arbiter
//  Description : Time-slot scheduler for the single-port framebuffer BRAM.
//                Phase 0 of every SLOTS-cycle pixel period reads the scan-out
//                pixel; remaining phases serve two requesters round-robin.
//                Optional macro FB_BLANK_YIELD_EN hands the display slot to
//                the requesters while DISP_ACTIVE is low.
//  Revision    : 1.0 - initial release
// ============================================================================
module fb_slot_arbiter #(
    parameter int SLOTS     = 4,
    parameter int MEM_DEPTH = 307200,
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = 24
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [ADDR_W-1:0]   DISP_ADDR,
    input  logic                DISP_ACTIVE,
    output logic [DATA_W-1:0]   DISP_DATA,
    output logic                DISP_VALID,
    input  logic [1:0]          REQ_VALID,
    input  logic [1:0]          REQ_WE,
    input  logic [2*ADDR_W-1:0] REQ_ADDR,
    input  logic [2*DATA_W-1:0] REQ_WDATA,
    output logic [1:0]          REQ_READY,
    output logic [1:0]          RD_VALID,
    output logic [DATA_W-1:0]   RD_DATA,
    output logic [ADDR_W-1:0]   MEM_ADDR,
    output logic                MEM_WE,
    output logic [DATA_W-1:0]   MEM_WDATA,
    input  logic [DATA_W-1:0]   MEM_RDATA
);

    import fb_pkg::*;

    localparam int               c_PH_W  = (SLOTS > 2) ? $clog2(SLOTS) : 1;
    localparam logic [ADDR_W:0]  c_DEPTH = (ADDR_W + 1)'(MEM_DEPTH);

    logic [c_PH_W-1:0] r_phase;
    slot_t             w_slot;
    logic [1:0]        w_req_mask;
    logic [1:0]        w_grant;
    logic              w_sel;
    logic [ADDR_W-1:0] w_req_addr;
    logic [DATA_W-1:0] w_req_wdata;
    logic              w_req_we;
    logic              w_in_range;
    logic              w_unused_rr_ptr;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_disp_pend;
    logic [DATA_W-1:0] r_disp_data;
    logic              r_disp_valid;
    logic [1:0]        r_rd_pend;
    logic              r_rd_oor;
    logic [DATA_W-1:0] r_rd_hold;

    // Free-running slot phase, wraps every pixel period
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_phase <= '0;
        end else if (r_phase == c_PH_W'(SLOTS - 1)) begin
            r_phase <= '0;
        end else begin
            r_phase <= r_phase + 1'b1;
        end
    end

`ifdef FB_BLANK_YIELD_EN
    // Phase 0 belongs to scan-out only while the beam is in the visible area
    always_comb begin
        w_slot = SLOT_REQ;
        if ((r_phase == '0) && DISP_ACTIVE) begin
            w_slot = SLOT_DISP;
        end
    end
`else
    logic w_unused_disp_active;
    assign w_unused_disp_active = DISP_ACTIVE;

    // Phase 0 always belongs to scan-out
    always_comb begin
        w_slot = SLOT_REQ;
        if (r_phase == '0) begin
            w_slot = SLOT_DISP;
        end
    end
`endif

    assign w_req_mask = (w_slot == SLOT_REQ) ? REQ_VALID : 2'b00;

    rr_arb2 u_arb (
        .clk     (CLK),
        .rst_n   (RST_N),
        .req     (w_req_mask),
        .advance (|w_grant),
        .grant   (w_grant),
        .ptr     (w_unused_rr_ptr)
    );

    assign REQ_READY   = w_grant;
    assign w_sel       = w_grant[1];
    assign w_req_addr  = w_sel ? REQ_ADDR[2*ADDR_W-1:ADDR_W]  : REQ_ADDR[ADDR_W-1:0];
    assign w_req_wdata = w_sel ? REQ_WDATA[2*DATA_W-1:DATA_W] : REQ_WDATA[DATA_W-1:0];
    assign w_req_we    = w_sel ? REQ_WE[1] : REQ_WE[0];
    assign w_in_range  = ({1'b0, w_req_addr} < c_DEPTH);

    // Memory port mux; address holds when the slot goes unused
    always_comb begin
        MEM_ADDR  = r_mem_addr;
        MEM_WE    = 1'b0;
        MEM_WDATA = w_req_wdata;
        if (w_slot == SLOT_DISP) begin
            MEM_ADDR = DISP_ADDR;
        end else if (|w_grant) begin
            MEM_ADDR = w_req_addr;
            MEM_WE   = w_req_we & w_in_range;
        end
    end

    // Remember the last driven address for idle slots
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_mem_addr <= '0;
        end else begin
            r_mem_addr <= MEM_ADDR;
        end
    end

    // Display pipeline: issue in phase 0, capture next cycle, flag the cycle after
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_disp_pend  <= 1'b0;
            r_disp_data  <= '0;
            r_disp_valid <= 1'b0;
        end else begin
            r_disp_pend  <= (w_slot == SLOT_DISP);
            r_disp_valid <= r_disp_pend;
            if (r_disp_pend) begin
                r_disp_data <= MEM_RDATA;
            end
        end
    end

    assign DISP_DATA  = r_disp_data;
    assign DISP_VALID = r_disp_valid;

    // Requester read tracking; out-of-range reads return zero
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rd_pend <= 2'b00;
            r_rd_oor  <= 1'b0;
            r_rd_hold <= '0;
        end else begin
            r_rd_pend <= w_grant & ~REQ_WE;
            if (|(w_grant & ~REQ_WE)) begin
                r_rd_oor <= ~w_in_range;
            end
            if (|r_rd_pend) begin
                r_rd_hold <= RD_DATA;
            end
        end
    end

    // BRAM data arrives in the return cycle; it is passed through then and held after
    assign RD_VALID = r_rd_pend;
    assign RD_DATA  = (|r_rd_pend) ? (r_rd_oor ? '0 : MEM_RDATA) : r_rd_hold;

endmodule : fb_slot_arbiter
`default_nettype wire

// File: tb/tb_fb_slot_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_fb_slot_arbiter
//  Description : Self-checking bench for fb_slot_arbiter with a BRAM model
//                that returns data equal to the address.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_slot_arbiter;

    localparam int SLOTS     = 4;
    localparam int MEM_DEPTH = 307200;
    localparam int ADDR_W    = 19;
    localparam int DATA_W    = 24;
`ifdef FB_BLANK_YIELD_EN
    localparam bit c_YIELD = 1'b1;
`else
    localparam bit c_YIELD = 1'b0;
`endif

    logic                CLK = 1'b0;
    logic                RST_N;
    logic [ADDR_W-1:0]   DISP_ADDR;
    logic                DISP_ACTIVE;
    logic [DATA_W-1:0]   DISP_DATA;
    logic                DISP_VALID;
    logic [1:0]          REQ_VALID;
    logic [1:0]          REQ_WE;
    logic [2*ADDR_W-1:0] REQ_ADDR;
    logic [2*DATA_W-1:0] REQ_WDATA;
    logic [1:0]          REQ_READY;
    logic [1:0]          RD_VALID;
    logic [DATA_W-1:0]   RD_DATA;
    logic [ADDR_W-1:0]   MEM_ADDR;
    logic                MEM_WE;
    logic [DATA_W-1:0]   MEM_WDATA;
    logic [DATA_W-1:0]   MEM_RDATA = '0;

    typedef struct {
        logic [1:0]        vld;
        logic [DATA_W-1:0] data;
    } rd_exp_t;

    rd_exp_t           rd_q[$];
    logic [DATA_W-1:0] disp_q[$];
    int                n_cmp = 0;
    int                n_err = 0;
    int                ph;

    always #5 CLK = ~CLK;

    fb_slot_arbiter #(
        .SLOTS(SLOTS), .MEM_DEPTH(MEM_DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .DISP_ADDR(DISP_ADDR), .DISP_ACTIVE(DISP_ACTIVE),
        .DISP_DATA(DISP_DATA), .DISP_VALID(DISP_VALID), .REQ_VALID(REQ_VALID),
        .REQ_WE(REQ_WE), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
        .REQ_READY(REQ_READY), .RD_VALID(RD_VALID), .RD_DATA(RD_DATA),
        .MEM_ADDR(MEM_ADDR), .MEM_WE(MEM_WE), .MEM_WDATA(MEM_WDATA),
        .MEM_RDATA(MEM_RDATA)
    );

    // BRAM model: one-cycle latency, data equals address
    always @(posedge CLK) MEM_RDATA <= 24'(MEM_ADDR);

    // Reference phase: 0 in reset, then counts 0..SLOTS-1
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) ph <= 0;
        else        ph <= (ph + 1) % SLOTS;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic sync_phase(input int target);
        int guard = 0;
        while (ph != target && guard < 2 * SLOTS) begin
            step();
            guard++;
        end
        n_cmp++;
        if (ph != target) begin
            n_err++;
            $display("FAIL sync_phase: got phase %0d expected %0d", ph, target);
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0; DISP_ADDR = 19'd5; DISP_ACTIVE = 1'b1;
        REQ_VALID = 2'b00; REQ_WE = 2'b00; REQ_ADDR = '0; REQ_WDATA = '0;
        repeat (3) @(posedge CLK);
        #1;
        n_cmp++; if (DISP_DATA !== 24'h0)   begin n_err++; $display("FAIL reset_disp_data: got %h expected %h", DISP_DATA, 24'h0); end
        n_cmp++; if (DISP_VALID !== 1'b0)   begin n_err++; $display("FAIL reset_disp_valid: got %b expected 0", DISP_VALID); end
        n_cmp++; if (RD_VALID !== 2'b00)    begin n_err++; $display("FAIL reset_rd_valid: got %b expected 00", RD_VALID); end
        n_cmp++; if (RD_DATA !== 24'h0)     begin n_err++; $display("FAIL reset_rd_data: got %h expected %h", RD_DATA, 24'h0); end
        n_cmp++; if (MEM_ADDR !== 19'd5)    begin n_err++; $display("FAIL reset_mem_addr: got %0d expected 5", MEM_ADDR); end
        RST_N = 1'b1;
    endtask

    task automatic test_display();
        for (int c = 0; c < 12; c++) begin
            if (ph == 0) disp_q.push_back(24'(DISP_ADDR));
            #4;
            n_cmp++; if (MEM_WE !== 1'b0)     begin n_err++; $display("FAIL disp_mem_we: got %b expected 0 (phase %0d)", MEM_WE, ph); end
            n_cmp++; if (REQ_READY !== 2'b00) begin n_err++; $display("FAIL disp_ready: got %b expected 00 (phase %0d)", REQ_READY, ph); end
            if (ph == 0) begin
                n_cmp++; if (MEM_ADDR !== 19'd5) begin n_err++; $display("FAIL disp_mem_addr: got %0d expected 5", MEM_ADDR); end
            end
            n_cmp++;
            if (DISP_VALID !== (ph == 2)) begin
                n_err++; $display("FAIL disp_valid: got %b expected %b (phase %0d)", DISP_VALID, (ph == 2), ph);
            end
            if (DISP_VALID === 1'b1) begin
                n_cmp++;
                if (disp_q.size() == 0) begin
                    n_err++; $display("FAIL disp_data: got %h with no display read outstanding", DISP_DATA);
                end else begin
                    logic [DATA_W-1:0] exp_d;
                    exp_d = disp_q.pop_front();
                    if (DISP_DATA !== exp_d) begin n_err++; $display("FAIL disp_data: got %h expected %h", DISP_DATA, exp_d); end
                end
            end
            step();
        end
    endtask

    task automatic test_both_write();
        int k = 0, cnt0 = 0, cnt1 = 0;
        logic [1:0] exp_rdy;
        sync_phase(0);
        REQ_VALID = 2'b11; REQ_WE = 2'b11;
        REQ_ADDR  = {19'd20, 19'd10};
        REQ_WDATA = {24'hBBBB02, 24'hAAAA01};
        for (int c = 0; c < 8; c++) begin
            #4;
            if (ph == 0) begin
                exp_rdy = 2'b00;
            end else begin
                exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
                k++;
            end
            n_cmp++; if (REQ_READY !== exp_rdy) begin n_err++; $display("FAIL bw_ready: got %b expected %b (phase %0d)", REQ_READY, exp_rdy, ph); end
            n_cmp++; if (MEM_WE !== (ph != 0))  begin n_err++; $display("FAIL bw_mem_we: got %b expected %b (phase %0d)", MEM_WE, (ph != 0), ph); end
            if (exp_rdy == 2'b01) begin
                n_cmp++; if (MEM_ADDR !== 19'd10 || MEM_WDATA !== 24'hAAAA01) begin n_err++; $display("FAIL bw_port0: got %0d/%h expected 10/aaaa01", MEM_ADDR, MEM_WDATA); end
            end else if (exp_rdy == 2'b10) begin
                n_cmp++; if (MEM_ADDR !== 19'd20 || MEM_WDATA !== 24'hBBBB02) begin n_err++; $display("FAIL bw_port1: got %0d/%h expected 20/bbbb02", MEM_ADDR, MEM_WDATA); end
            end
            if (REQ_READY[0] === 1'b1) cnt0++;
            if (REQ_READY[1] === 1'b1) cnt1++;
            step();
        end
        REQ_VALID = 2'b00;
        n_cmp++; if (cnt0 != 3 || cnt1 != 3) begin n_err++; $display("FAIL bw_counts: got %0d/%0d expected 3/3", cnt0, cnt1); end
    endtask

    task automatic test_read();
        rd_exp_t e;
        sync_phase(1);
        REQ_VALID = 2'b01; REQ_WE = 2'b00; REQ_ADDR = {19'd0, 19'd100};
        #4;
        n_cmp++; if (REQ_READY !== 2'b01 || MEM_ADDR !== 19'd100 || MEM_WE !== 1'b0) begin
            n_err++; $display("FAIL rd_grant: got rdy=%b addr=%0d we=%b expected 01/100/0", REQ_READY, MEM_ADDR, MEM_WE);
        end
        if (REQ_READY[0] === 1'b1) rd_q.push_back('{vld: 2'b01, data: 24'h000064});
        step();
        REQ_VALID = 2'b00;
        #4;
        n_cmp++;
        if (rd_q.size() == 0) begin
            n_err++; $display("FAIL rd_return: got rd_valid=%b with no read outstanding", RD_VALID);
        end else begin
            e = rd_q.pop_front();
            if (RD_VALID !== e.vld || RD_DATA !== e.data) begin
                n_err++; $display("FAIL rd_return: got %b/%h expected %b/%h", RD_VALID, RD_DATA, e.vld, e.data);
            end
        end
        n_cmp++; if (DISP_VALID !== 1'b1 || DISP_DATA !== 24'h5) begin n_err++; $display("FAIL rd_disp_same_cycle: got %b/%h expected 1/000005", DISP_VALID, DISP_DATA); end
        step();
        #4;
        n_cmp++; if (RD_VALID !== 2'b00 || RD_DATA !== 24'h64) begin n_err++; $display("FAIL rd_hold: got %b/%h expected 00/000064", RD_VALID, RD_DATA); end
        step();
    endtask

    task automatic test_oor();
        rd_exp_t e;
        sync_phase(1);
        REQ_VALID = 2'b10; REQ_WE = 2'b10; REQ_ADDR = {19'd307200, 19'd0}; REQ_WDATA = {24'h123456, 24'h0};
        #4;
        n_cmp++; if (REQ_READY !== 2'b10 || MEM_WE !== 1'b0) begin n_err++; $display("FAIL oor_write: got rdy=%b we=%b expected 10/0", REQ_READY, MEM_WE); end
        step();
        REQ_WE = 2'b00;
        #4;
        n_cmp++; if (REQ_READY !== 2'b10) begin n_err++; $display("FAIL oor_read_grant: got %b expected 10", REQ_READY); end
        n_cmp++; if (RD_VALID !== 2'b00 || RD_DATA !== 24'h64) begin n_err++; $display("FAIL oor_write_noresp: got %b/%h expected 00/000064", RD_VALID, RD_DATA); end
        if (REQ_READY[1] === 1'b1) rd_q.push_back('{vld: 2'b10, data: 24'h0});
        step();
        REQ_VALID = 2'b00;
        #4;
        n_cmp++;
        if (rd_q.size() == 0) begin
            n_err++; $display("FAIL oor_read_return: got rd_valid=%b with no read outstanding", RD_VALID);
        end else begin
            e = rd_q.pop_front();
            if (RD_VALID !== e.vld || RD_DATA !== e.data) begin
                n_err++; $display("FAIL oor_read_return: got %b/%h expected %b/%h", RD_VALID, RD_DATA, e.vld, e.data);
            end
        end
        step();
    endtask

    task automatic test_reset_midread();
        sync_phase(1);
        REQ_VALID = 2'b01; REQ_WE = 2'b00; REQ_ADDR = {19'd0, 19'd200};
        #4;
        n_cmp++; if (REQ_READY !== 2'b01) begin n_err++; $display("FAIL mr_grant: got %b expected 01", REQ_READY); end
        step();
        REQ_VALID = 2'b00;
        RST_N = 1'b0;
        #1;
        n_cmp++; if (RD_VALID !== 2'b00 || RD_DATA !== 24'h0) begin n_err++; $display("FAIL mr_rd_cleared: got %b/%h expected 00/000000", RD_VALID, RD_DATA); end
        n_cmp++; if (DISP_DATA !== 24'h0 || DISP_VALID !== 1'b0) begin n_err++; $display("FAIL mr_disp_cleared: got %h/%b expected 000000/0", DISP_DATA, DISP_VALID); end
        rd_q.delete();
        step();
        RST_N = 1'b1;
        REQ_VALID = 2'b11; REQ_WE = 2'b11; REQ_ADDR = {19'd40, 19'd30};
        #4;
        n_cmp++; if (REQ_READY !== 2'b00 || MEM_ADDR !== 19'd5) begin n_err++; $display("FAIL mr_phase0: got rdy=%b addr=%0d expected 00/5", REQ_READY, MEM_ADDR); end
        step();
        #4;
        n_cmp++; if (REQ_READY !== 2'b01) begin n_err++; $display("FAIL mr_ptr_restored: got %b expected 01", REQ_READY); end
        step();
        REQ_VALID = 2'b00;
    endtask

    task automatic test_yield();
        logic [1:0] exp_rdy;
        logic       exp_dv;
        sync_phase(0);
        DISP_ACTIVE = 1'b0;
        REQ_VALID = 2'b01; REQ_WE = 2'b01; REQ_ADDR = {19'd0, 19'd50}; REQ_WDATA = {24'h0, 24'hC0FFEE};
        for (int c = 0; c < 8; c++) begin
            #4;
            exp_rdy = (ph != 0 || c_YIELD) ? 2'b01 : 2'b00;
            exp_dv  = c_YIELD ? 1'b0 : (ph == 2);
            n_cmp++; if (REQ_READY !== exp_rdy)  begin n_err++; $display("FAIL yield_ready: got %b expected %b (phase %0d)", REQ_READY, exp_rdy, ph); end
            n_cmp++; if (DISP_VALID !== exp_dv)  begin n_err++; $display("FAIL yield_disp_valid: got %b expected %b (phase %0d)", DISP_VALID, exp_dv, ph); end
            n_cmp++; if (DISP_DATA !== 24'h5)    begin n_err++; $display("FAIL yield_disp_data: got %h expected 000005", DISP_DATA); end
            step();
        end
        REQ_VALID = 2'b00;
        DISP_ACTIVE = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_display();
        test_both_write();
        test_read();
        test_oor();
        test_reset_midread();
        test_yield();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_fb_slot_arbiter
`default_nettype wire
